// File: rtl/lif_pkg.sv
// Shared types and defaults for the leaky integrate-and-fire neuron stage.
package lif_pkg;

  // Neuron control states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INTEG  = 2'd1,
    S_REFRAC = 2'd2
  } lif_state_t;

  // Default build constants
  localparam int LIF_DW         = 8;
  localparam int LIF_VW         = 12;
  localparam int LIF_THRESH     = 1024;
  localparam int LIF_LEAK_SHIFT = 4;
  localparam int LIF_REFRAC     = 3;

  // Unsigned add clamped at lim; operands are far narrower than 32 bits,
  // so the raw sum cannot wrap before the clamp.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/lif_leak_sat.sv
// Combinational leak-plus-input saturating accumulator for one neuron.
module lif_leak_sat import lif_pkg::*; #(
  parameter int DW         = LIF_DW,
  parameter int VW         = LIF_VW,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
  input  logic [VW-1:0] i_vmem,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic [VW-1:0] o_acc
);

  logic [VW-1:0] w_leaked;
  logic [DW-1:0] w_in;
  int unsigned   w_sum;

  // LEAK_SHIFT >= 1 keeps the leak strictly below vmem, so no underflow.
  assign w_leaked = i_vmem - (i_vmem >> LEAK_SHIFT);
  assign w_in     = i_valid ? i_data : '0;
  assign w_sum    = sat_add(32'(w_leaked), 32'(w_in), (32'd1 << VW) - 32'd1);
  assign o_acc    = VW'(w_sum);

endmodule

// File: rtl/lif_neuron_acc.sv
// Leaky integrate-and-fire neuron fed by the synaptic adder stage.
// Optional spike counter output enabled by defining LIF_SPIKE_CNT_EN.
module lif_neuron_acc import lif_pkg::*; #(
  parameter int DW         = LIF_DW,
  parameter int VW         = LIF_VW,
  parameter int THRESH     = LIF_THRESH,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
  parameter int REFRAC     = LIF_REFRAC
) (
  input  logic          CK,
  input  logic          RSTB,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          spike,
  output logic [VW-1:0] vmem,
  output logic          refrac_busy
`ifdef LIF_SPIKE_CNT_EN
  ,
  output logic [15:0]   spike_cnt
`endif
);

  localparam int CW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

  lif_state_t    r_state, w_state_nx;
  logic [VW-1:0] r_vmem, w_vmem_nx, w_acc;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_spike;
  logic          w_fire;
  logic          w_sample;

  // Samples only count while integrating; anything else is dropped.
  assign w_sample = in_valid && (r_state == S_INTEG);

  lif_leak_sat #(
    .DW(DW), .VW(VW), .LEAK_SHIFT(LEAK_SHIFT)
  ) u_leak_sat (
    .i_vmem (r_vmem),
    .i_valid(w_sample),
    .i_data (in_data),
    .o_acc  (w_acc)
  );

  assign w_fire = (r_state == S_INTEG) && (w_acc >= VW'(THRESH));

  // Next-state, next-potential and refractory countdown
  always_comb begin
    w_state_nx = r_state;
    w_vmem_nx  = r_vmem;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nx = S_INTEG;
      end
      S_INTEG: begin
        if (w_fire) begin
          w_vmem_nx  = '0;
          w_cnt_nx   = CW'(REFRAC);
          w_state_nx = (REFRAC == 0) ? S_INTEG : S_REFRAC;
        end else begin
          w_vmem_nx = w_acc;
          if (!enable) w_state_nx = S_IDLE;
        end
      end
      S_REFRAC: begin
        w_vmem_nx = '0;
        w_cnt_nx  = r_cnt - CW'(1);
        // <= also rescues a counter that somehow reached 0 here
        if (r_cnt <= CW'(1)) begin
          w_cnt_nx   = '0;
          w_state_nx = enable ? S_INTEG : S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, potential, counter and registered spike pulse
  always_ff @(posedge CK) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
      r_vmem  <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_vmem  <= w_vmem_nx;
      r_cnt   <= w_cnt_nx;
      r_spike <= w_fire;
    end
  end

  assign in_ready    = (r_state == S_INTEG);
  assign refrac_busy = (r_state == S_REFRAC);
  assign spike       = r_spike;
  assign vmem        = r_vmem;

`ifdef LIF_SPIKE_CNT_EN
  logic [15:0] r_spike_cnt;

  // Count spikes in step with the spike register, sticking at all-ones
  always_ff @(posedge CK) begin
    if (!RSTB) begin
      r_spike_cnt <= '0;
    end else if (w_fire && (r_spike_cnt != 16'hFFFF)) begin
      r_spike_cnt <= r_spike_cnt + 16'd1;
    end
  end

  assign spike_cnt = r_spike_cnt;
`endif

endmodule

// File: tb/tb_lif_neuron_acc.sv
// Directed bench for lif_neuron_acc: default instance plus a REFRAC=0 one.
module tb_lif_neuron_acc;

  logic        CK = 1'b0;
  logic        RSTB, enable, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, spike, refrac_busy;
  logic [11:0] vmem;
  logic        u1_ready, u1_spike, u1_busy;
  logic [11:0] u1_vmem;
`ifdef LIF_SPIKE_CNT_EN
  logic [15:0] spike_cnt, u1_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  lif_neuron_acc dut (
    .CK(CK), .RSTB(RSTB), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .spike(spike), .vmem(vmem), .refrac_busy(refrac_busy)
`ifdef LIF_SPIKE_CNT_EN
    , .spike_cnt(spike_cnt)
`endif
  );

  lif_neuron_acc #(.THRESH(200), .REFRAC(0)) u1 (
    .CK(CK), .RSTB(RSTB), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(u1_ready), .spike(u1_spike), .vmem(u1_vmem), .refrac_busy(u1_busy)
`ifdef LIF_SPIKE_CNT_EN
    , .spike_cnt(u1_cnt)
`endif
  );

  typedef struct {
    logic        rstb, en, vld;
    logic [7:0]  data;
    logic [11:0] vmem;
    logic        spk, rdy, bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rstb, en, vld, input logic [7:0] data,
                              input logic [11:0] vm, input logic spk, rdy, bsy);
    vec_t v;
    v.rstb = rstb; v.en = en; v.vld = vld; v.data = data;
    v.vmem = vm; v.spk = spk; v.rdy = rdy; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic rstb, en, vld, input logic [7:0] data);
    RSTB = rstb; enable = en; in_valid = vld; in_data = data;
  endtask

  initial begin
    int seen;
    logic prev_spk;

    // Inputs applied before an edge; expectations are outputs after it.
    tbl.push_back(mk(0,0,1,255,   0,0,0,0));  // reset with live input
    tbl.push_back(mk(0,0,1,255,   0,0,0,0));
    tbl.push_back(mk(1,1,1,255,   0,0,1,0));  // IDLE->INTEG, sample dropped
    tbl.push_back(mk(1,1,1,255, 255,0,1,0));
    tbl.push_back(mk(1,1,1,255, 495,0,1,0));
    tbl.push_back(mk(1,1,1,255, 720,0,1,0));
    tbl.push_back(mk(1,1,1,255, 930,0,1,0));
    tbl.push_back(mk(1,1,1,255,   0,1,0,1));  // acc=1127 fires
    tbl.push_back(mk(1,1,1,255,   0,0,0,1));
    tbl.push_back(mk(1,1,1,255,   0,0,0,1));
    tbl.push_back(mk(1,1,1,255,   0,0,1,0));  // refractory over
    tbl.push_back(mk(1,1,1,255, 255,0,1,0));
    tbl.push_back(mk(1,1,1,255, 495,0,1,0));
    tbl.push_back(mk(1,1,0,255, 465,0,1,0));  // leak only
    tbl.push_back(mk(1,1,0,255, 436,0,1,0));
    tbl.push_back(mk(1,1,0,255, 409,0,1,0));
    tbl.push_back(mk(1,0,0,  0, 384,0,0,0));  // last leak applied, to IDLE
    tbl.push_back(mk(1,0,1,255, 384,0,0,0));  // frozen, input dropped
    tbl.push_back(mk(1,0,1,255, 384,0,0,0));
    tbl.push_back(mk(1,1,1,255, 384,0,1,0));
    tbl.push_back(mk(1,1,1,255, 615,0,1,0));
    tbl.push_back(mk(1,1,1,255, 832,0,1,0));
    tbl.push_back(mk(1,0,1,255,   0,1,0,1));  // fires even with enable=0
    tbl.push_back(mk(1,0,1,255,   0,0,0,1));  // enable=0 keeps full refractory
    tbl.push_back(mk(1,0,1,255,   0,0,0,1));
    tbl.push_back(mk(1,0,1,255,   0,0,0,0));  // exits to IDLE
    tbl.push_back(mk(1,0,1,255,   0,0,0,0));

    drive(0, 0, 0, 8'd0);
    foreach (tbl[i]) begin
      drive(tbl[i].rstb, tbl[i].en, tbl[i].vld, tbl[i].data);
      tick();
      chk($sformatf("v%0d vmem", i),  int'(vmem),        int'(tbl[i].vmem));
      chk($sformatf("v%0d spike", i), int'(spike),       int'(tbl[i].spk));
      chk($sformatf("v%0d ready", i), int'(in_ready),    int'(tbl[i].rdy));
      chk($sformatf("v%0d busy", i),  int'(refrac_busy), int'(tbl[i].bsy));
    end
`ifdef LIF_SPIKE_CNT_EN
    chk("cnt after table", int'(spike_cnt), 2);
`endif

    // Zero input for 50 cycles
    drive(0, 0, 0, 8'd0); tick(); tick();
    drive(1, 1, 1, 8'd0); tick();
    for (int t = 0; t < 50; t++) begin
      tick();
      chk($sformatf("zero vmem t%0d", t), int'(vmem), 0);
      chk($sformatf("zero spike t%0d", t), int'(spike), 0);
    end

    // Reset on the second refractory cycle
    in_data = 8'd255;
    tick(); chk("rr vmem1", int'(vmem), 255);
    tick(); chk("rr vmem2", int'(vmem), 495);
    tick(); chk("rr vmem3", int'(vmem), 720);
    tick(); chk("rr vmem4", int'(vmem), 930);
    tick(); chk("rr spike", int'(spike), 1); chk("rr busy1", int'(refrac_busy), 1);
    tick(); chk("rr busy2", int'(refrac_busy), 1); chk("rr spike off", int'(spike), 0);
    RSTB = 1'b0;
    tick();
    chk("rr rst busy", int'(refrac_busy), 0);
    chk("rr rst vmem", int'(vmem), 0);
    chk("rr rst ready", int'(in_ready), 0);
    chk("rr rst spike", int'(spike), 0);
    RSTB = 1'b1;
    tick(); chk("rr integ", int'(in_ready), 1);

    // Three fire events on the default instance; REFRAC=0 instance alongside
    drive(0, 1, 1, 8'd255); tick();
    RSTB = 1'b1;
    seen = 0;
    prev_spk = 1'b0;
    for (int t = 0; t < 100 && seen < 3; t++) begin
      tick();
      if (spike) seen++;
      chk($sformatf("pulse width t%0d", t), int'(spike && prev_spk), 0);
      prev_spk = spike;
      chk($sformatf("u1 ready t%0d", t), int'(u1_ready), 1);
      chk($sformatf("u1 spike t%0d", t), int'(u1_spike), (t == 0) ? 0 : 1);
      chk($sformatf("u1 vmem t%0d", t), int'(u1_vmem), 0);
    end
    chk("three spikes seen", seen, 3);
`ifdef LIF_SPIKE_CNT_EN
    chk("spike_cnt", int'(spike_cnt), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
